// File: rtl/gpio_pad_pkg.sv
// gpio_pad_pkg
// Shared parameters and types for the GPIO pad conditioning slice.
//   GPIO_NUM_PINS  : default number of pins handled by gpio_pad_ctrl
//   GPIO_FILT_W    : default width of the glitch-filter threshold/counter
//   gpio_pin_cfg_t : per-pin configuration bundle seen by one pad
//   pad_drive()    : maps a pin configuration to the {c2p, c2p_en} pad drive
package gpio_pad_pkg;

  localparam int GPIO_NUM_PINS = 8;
  localparam int GPIO_FILT_W   = 4;

  typedef struct packed {
    logic out;
    logic oe;
    logic od;
    logic rise_en;
    logic fall_en;
  } gpio_pin_cfg_t;

  // Open-drain never drives a 1: it only enables the driver to pull low,
  // leaving the high level to the external pull-up.
  function automatic logic [1:0] pad_drive(input gpio_pin_cfg_t cfg);
    logic [1:0] drv;
    if (cfg.od) begin
      drv = {1'b0, cfg.oe & ~cfg.out};
    end else begin
      drv = {cfg.out, cfg.oe};
    end
    return drv;
  endfunction

endpackage

// File: rtl/gpio_pad_filt.sv
// gpio_pad_filt
// Input conditioning for one pin: two-flop synchroniser, glitch filter,
// edge detection and sticky interrupt pending bit.
//   clk_i, rst_i  : core clock, asynchronous active-high reset
//   p2c_i         : raw pad input (asynchronous)
//   filt_thr_i    : filter threshold in cycles (0 behaves as 1)
//   rise_en_i     : rising-edge pending enable
//   fall_en_i     : falling-edge pending enable
//   pend_clr_i    : one-cycle clear of the pending bit
//   in_o          : filtered, synchronised level
//   pend_o        : sticky pending bit
//   pend_next_o   : next-cycle value of the pending bit (for the irq OR)
module gpio_pad_filt
  import gpio_pad_pkg::*;
#(
  parameter int FILT_W = GPIO_FILT_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              p2c_i,
  input  logic [FILT_W-1:0] filt_thr_i,
  input  logic              rise_en_i,
  input  logic              fall_en_i,
  input  logic              pend_clr_i,
  output logic              in_o,
  output logic              pend_o,
  output logic              pend_next_o
);

  logic              s1_reg;
  logic              s2_reg;
  logic              stable_reg;
  logic              stable_next;
  logic              pend_reg;
  logic              pend_next;
  logic [FILT_W-1:0] cnt_reg;
  logic [FILT_W-1:0] cnt_next;
  logic [FILT_W-1:0] thr_m1;
  logic              rise;
  logic              fall;

  // thr-1 with thr clamped to at least 1; the max value is 2^FILT_W-2,
  // so the counter can never wrap before the compare fires.
  assign thr_m1 = (filt_thr_i == '0) ? '0 : filt_thr_i - 1'b1;

  always_comb begin
    stable_next = stable_reg;
    cnt_next    = cnt_reg;
    if (s2_reg == stable_reg) begin
      cnt_next = '0;
    end else if (cnt_reg >= thr_m1) begin
      // >= so that lowering the threshold mid-count completes immediately
      stable_next = s2_reg;
      cnt_next    = '0;
    end else begin
      cnt_next = cnt_reg + 1'b1;
    end
  end

  assign rise = ~stable_reg & stable_next;
  assign fall = stable_reg & ~stable_next;

  // A new enabled edge beats a same-cycle clear so no event is lost.
  always_comb begin
    pend_next = pend_reg;
    if ((rise & rise_en_i) | (fall & fall_en_i)) begin
      pend_next = 1'b1;
    end else if (pend_clr_i) begin
      pend_next = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_reg     <= 1'b0;
      s2_reg     <= 1'b0;
      stable_reg <= 1'b0;
      cnt_reg    <= '0;
      pend_reg   <= 1'b0;
    end else begin
      s1_reg     <= p2c_i;
      s2_reg     <= s1_reg;
      stable_reg <= stable_next;
      cnt_reg    <= cnt_next;
      pend_reg   <= pend_next;
    end
  end

  assign in_o        = stable_reg;
  assign pend_o      = pend_reg;
  assign pend_next_o = pend_next;

endmodule

// File: rtl/gpio_pad_ctrl.sv
// gpio_pad_ctrl
// Per-pin GPIO conditioning between the register file and tri-state pads.
//   clk_i, rst_i : core clock, asynchronous active-high reset
//   out_i, oe_i, od_i        : output data, output enable, open-drain select
//   filt_thr_i               : shared glitch-filter threshold (0 behaves as 1)
//   rise_en_i, fall_en_i     : per-pin edge interrupt enables
//   pend_clr_i               : per-pin pending clear pulses
//   c2p_o, c2p_en_o          : registered pad drive
//   p2c_i                    : asynchronous pad input
//   in_o                     : filtered, synchronised pin levels
//   pend_o                   : sticky pending bits
//   irq_o                    : registered OR of the pending bits
module gpio_pad_ctrl
  import gpio_pad_pkg::*;
#(
  parameter int NUM_PINS = GPIO_NUM_PINS,
  parameter int FILT_W   = GPIO_FILT_W
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [NUM_PINS-1:0] out_i,
  input  logic [NUM_PINS-1:0] oe_i,
  input  logic [NUM_PINS-1:0] od_i,
  input  logic [FILT_W-1:0]   filt_thr_i,
  input  logic [NUM_PINS-1:0] rise_en_i,
  input  logic [NUM_PINS-1:0] fall_en_i,
  input  logic [NUM_PINS-1:0] pend_clr_i,
  output logic [NUM_PINS-1:0] c2p_o,
  output logic [NUM_PINS-1:0] c2p_en_o,
  input  logic [NUM_PINS-1:0] p2c_i,
  output logic [NUM_PINS-1:0] in_o,
  output logic [NUM_PINS-1:0] pend_o,
  output logic                irq_o
);

  logic [NUM_PINS-1:0] c2p_next;
  logic [NUM_PINS-1:0] c2p_en_next;
  logic [NUM_PINS-1:0] c2p_reg;
  logic [NUM_PINS-1:0] c2p_en_reg;
  logic [NUM_PINS-1:0] pend_next;
  logic                irq_reg;

  for (genvar gi = 0; gi < NUM_PINS; gi++) begin : g_pin
    gpio_pin_cfg_t cfg;
    logic [1:0]    drv;

    assign cfg = '{out:     out_i[gi],
                   oe:      oe_i[gi],
                   od:      od_i[gi],
                   rise_en: rise_en_i[gi],
                   fall_en: fall_en_i[gi]};
    assign drv = pad_drive(cfg);
    assign c2p_next[gi]    = drv[1];
    assign c2p_en_next[gi] = drv[0];

    gpio_pad_filt #(
      .FILT_W(FILT_W)
    ) u_filt (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .p2c_i       (p2c_i[gi]),
      .filt_thr_i  (filt_thr_i),
      .rise_en_i   (cfg.rise_en),
      .fall_en_i   (cfg.fall_en),
      .pend_clr_i  (pend_clr_i[gi]),
      .in_o        (in_o[gi]),
      .pend_o      (pend_o[gi]),
      .pend_next_o (pend_next[gi])
    );
  end

  // irq follows the next pending value so it asserts on the same edge
  // as the pending bit that causes it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      c2p_reg    <= '0;
      c2p_en_reg <= '0;
      irq_reg    <= 1'b0;
    end else begin
      c2p_reg    <= c2p_next;
      c2p_en_reg <= c2p_en_next;
      irq_reg    <= |pend_next;
    end
  end

  assign c2p_o    = c2p_reg;
  assign c2p_en_o = c2p_en_reg;
  assign irq_o    = irq_reg;

endmodule

// File: tb/tb_gpio_pad_ctrl.sv
// tb_gpio_pad_ctrl
// Directed scenarios with literal expectations, followed by randomised
// traffic; a behavioural model is compared against the DUT every cycle.
module tb_gpio_pad_ctrl;
  localparam int N  = 8;
  localparam int FW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  out_v, oe_v, od_v, rise_en, fall_en, pend_clr, p2c;
  logic [FW-1:0] thr;
  logic [N-1:0]  c2p, c2p_en, in_v, pend;
  logic          irq;

  int checks = 0;
  int errors = 0;

  gpio_pad_ctrl #(.NUM_PINS(N), .FILT_W(FW)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .out_i      (out_v),
    .oe_i       (oe_v),
    .od_i       (od_v),
    .filt_thr_i (thr),
    .rise_en_i  (rise_en),
    .fall_en_i  (fall_en),
    .pend_clr_i (pend_clr),
    .c2p_o      (c2p),
    .c2p_en_o   (c2p_en),
    .p2c_i      (p2c),
    .in_o       (in_v),
    .pend_o     (pend),
    .irq_o      (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The pad line sampled two clocks ago is what the filter sees; the
  // filtered level follows it only once it has disagreed for thr
  // consecutive clocks (thr read freshly every clock, 0 meaning 1).
  bit [N-1:0] m_c2p, m_en, m_p1, m_p2, m_level, m_pend;
  bit         m_irq;
  int         m_run [N];

  always @(posedge clk or posedge rst) begin
    int  thr_eff;
    bit  new_level;
    if (rst) begin
      m_c2p = '0; m_en = '0; m_p1 = '0; m_p2 = '0;
      m_level = '0; m_pend = '0; m_irq = 1'b0;
      for (int i = 0; i < N; i++) m_run[i] = 0;
    end else begin
      thr_eff = (thr == 0) ? 1 : int'(thr);
      for (int i = 0; i < N; i++) begin
        // open-drain: line only ever pulled low, when enabled and out is 0
        m_c2p[i] = od_v[i] ? 1'b0 : out_v[i];
        m_en[i]  = od_v[i] ? (oe_v[i] && !out_v[i]) : oe_v[i];
        new_level = m_level[i];
        if (m_p2[i] == m_level[i]) begin
          m_run[i] = 0;
        end else if (m_run[i] + 1 >= thr_eff) begin
          new_level = m_p2[i];
          m_run[i]  = 0;
        end else begin
          m_run[i] = m_run[i] + 1;
        end
        if ((new_level && !m_level[i] && rise_en[i]) ||
            (!new_level && m_level[i] && fall_en[i]))
          m_pend[i] = 1'b1;
        else if (pend_clr[i])
          m_pend[i] = 1'b0;
        m_level[i] = new_level;
        m_p2[i] = m_p1[i];
        m_p1[i] = p2c[i];
      end
      m_irq = (m_pend != 0);
    end
  end

  // Compare process: every falling edge, well away from the active edge.
  always @(negedge clk) begin
    check("model in_o",     in_v,   m_level);
    check("model pend_o",   pend,   m_pend);
    check("model irq_o",    {{(N-1){1'b0}}, irq}, {{(N-1){1'b0}}, m_irq});
    check("model c2p_o",    c2p,    m_c2p);
    check("model c2p_en_o", c2p_en, m_en);
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic check_all_zero(input string name);
    check({name, " in_o"},   in_v,   '0);
    check({name, " pend_o"}, pend,   '0);
    check({name, " irq_o"},  {{(N-1){1'b0}}, irq}, '0);
    check({name, " c2p_o"},  c2p,    '0);
    check({name, " c2p_en"}, c2p_en, '0);
  endtask

  initial begin
    rst = 1'b1;
    out_v = '0; oe_v = '0; od_v = '0; rise_en = '0; fall_en = '0;
    pend_clr = '0; p2c = '0; thr = '0;
    tick(3);
    check_all_zero("reset");

    // ---- asynchronous reset mid-cycle with pad high and driving ----
    rst = 1'b0; p2c = '1; oe_v = '1; out_v = '1; rise_en = '1;
    tick(6);
    check("pre-reset in_o", in_v, 8'hFF);
    check("pre-reset c2p", c2p, 8'hFF);
    #2 rst = 1'b1;
    #1 check_all_zero("async reset");
    tick(1);
    rst = 1'b0;
    tick(2);
    check("post-reset in_o at 2", in_v, 8'h00);
    tick(1);
    check("post-reset in_o at 3", in_v, 8'hFF);
    check("post-reset pend", pend, 8'hFF);
    check("post-reset irq", {7'd0, irq}, 8'h01);
    check("post-reset c2p_en", c2p_en, 8'hFF);
    pend_clr = '1;
    tick(1);
    pend_clr = '0;
    check("clear pend", pend, 8'h00);
    check("clear irq", {7'd0, irq}, 8'h00);

    // ---- output modes ----
    od_v = '0; out_v = '1; oe_v = '1;
    tick(1);
    check("pp c2p", c2p, 8'hFF);
    check("pp c2p_en", c2p_en, 8'hFF);
    od_v = '1;
    check("od latency c2p", c2p, 8'hFF);
    tick(1);
    check("od out1 c2p", c2p, 8'h00);
    check("od out1 c2p_en", c2p_en, 8'h00);
    out_v = '0;
    tick(1);
    check("od out0 c2p", c2p, 8'h00);
    check("od out0 c2p_en", c2p_en, 8'hFF);

    // ---- glitch filter, thr=4 ----
    p2c = '0; rise_en = '1; fall_en = '0; thr = 4'd1;
    tick(5);
    check("filter setup in_o", in_v, 8'h00);
    thr = 4'd4;
    p2c = '1;
    tick(3);
    p2c = '0;
    for (int k = 0; k < 8; k++) begin
      tick(1);
      check("short glitch in_o", in_v, 8'h00);
      check("short glitch pend", pend, 8'h00);
    end
    p2c = '1;
    tick(4);
    p2c = '0;
    tick(1);
    check("filter in_o at 5", in_v, 8'h00);
    tick(1);
    check("filter in_o at 6", in_v, 8'hFF);
    check("filter pend", pend, 8'hFF);
    check("filter irq", {7'd0, irq}, 8'h01);
    tick(8);
    check("fall disabled in_o", in_v, 8'h00);
    check("fall disabled pend", pend, 8'hFF);

    // ---- clear collision, thr=1 ----
    thr = 4'd1; pend_clr = '1;
    tick(1);
    pend_clr = '0;
    check("collision pre pend", pend, 8'h00);
    p2c = '1;
    tick(2);
    pend_clr = '1;
    tick(1);
    check("collision in_o", in_v, 8'hFF);
    check("collision pend kept", pend, 8'hFF);
    check("collision irq", {7'd0, irq}, 8'h01);
    tick(1);
    pend_clr = '0;
    check("late clear pend", pend, 8'h00);
    check("late clear irq", {7'd0, irq}, 8'h00);
    p2c = '0;
    tick(4);
    check("fall only in_o", in_v, 8'h00);
    check("fall only pend", pend, 8'h00);

    // ---- threshold lowered mid-count ----
    p2c = '1; thr = 4'd8;
    tick(7);
    check("thr8 count5 in_o", in_v, 8'h00);
    thr = 4'd2;
    tick(1);
    check("thr lowered in_o", in_v, 8'hFF);

    // ---- randomised traffic ----
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) out_v = N'($urandom);
      if ($urandom_range(0, 7) == 0) oe_v  = N'($urandom);
      if ($urandom_range(0, 7) == 0) od_v  = N'($urandom);
      if ($urandom_range(0, 49) == 0) rise_en = N'($urandom);
      if ($urandom_range(0, 49) == 0) fall_en = N'($urandom);
      if ($urandom_range(0, 39) == 0) thr = FW'($urandom_range(0, 15));
      p2c ^= N'($urandom & $urandom & $urandom);
      pend_clr = ($urandom_range(0, 7) == 0) ? N'($urandom) : '0;
      if ($urandom_range(0, 499) == 0) begin
        #2 rst = 1'b1;
        tick(1);
        rst = 1'b0;
      end
      tick(1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
